addr_decode_shadowed: RTL and testbench

- Registered, runtime-reprogrammable address decoder. Maps a request address to a target index.
- Rules are written into a shadow table through a config port. A commit atomically copies the shadow table into the active table, but only after all in-flight decodes have drained.
- Sits in front of crossbar and demux select logic where the address map changes at runtime (boot remap, isolation) and must never be seen half-updated.

---
 rtl/addr_decode_shadowed.sv | 174 +++++++++++++++++
 tb/tb_addr_decode_shadowed.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_decode_shadowed.sv
// rtl/addr_decode_shadowed.sv - registered address decoder with shadow/active rule tables and drained commit
//
// Purpose: maps req_addr_i to a target index using the active rule table. Rules are
// staged in a shadow table through the cfg_* port; a commit copies the whole shadow
// table into the active table once the output register has drained, so a decode never
// sees a half-updated map.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   cfg_valid_i/cfg_ready_o    rule write handshake (ready only while IDLE)
//   cfg_sel_i/en/start/end/idx rule slot and contents
//   cfg_err_o                  pulse: last accepted write was rejected
//   cfg_commit_i               commit request (honoured only in IDLE)
//   cfg_busy_o                 commit in progress (DRAIN or COMMIT)
//   cfg_done_o                 pulse: active table has just been updated
//   en_default_idx_i           route misses to default_idx_i instead of flagging an error
//   req_valid_i/req_ready_o    decode request handshake, req_addr_i address
//   rsp_valid_o/rsp_ready_i    decode result handshake, rsp_idx_o / rsp_err_o result
//   miss_cnt_o, miss_clr_i     saturating miss counter and its clear
module addr_decode_shadowed #(
    parameter int unsigned NoIndices    = 32'd2,
    parameter int unsigned NoRules      = 32'd4,
    parameter int unsigned AddrWidth    = 32'd32,
    parameter bit          Napot        = 1'b0,
    parameter int unsigned IdxWidth     = (NoIndices > 1) ? $clog2(NoIndices) : 1,
    parameter int unsigned MissCntWidth = 32'd16,
    parameter int unsigned SelWidth     = (NoRules > 1) ? $clog2(NoRules) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [SelWidth-1:0]     cfg_sel_i,
    input  logic                    cfg_en_i,
    input  logic [AddrWidth-1:0]    cfg_start_i,
    input  logic [AddrWidth-1:0]    cfg_end_i,
    input  logic [IdxWidth-1:0]     cfg_idx_i,
    output logic                    cfg_err_o,
    input  logic                    cfg_commit_i,
    output logic                    cfg_busy_o,
    output logic                    cfg_done_o,
    input  logic                    en_default_idx_i,
    input  logic [IdxWidth-1:0]     default_idx_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrWidth-1:0]    req_addr_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [IdxWidth-1:0]     rsp_idx_o,
    output logic                    rsp_err_o,
    output logic [MissCntWidth-1:0] miss_cnt_o,
    input  logic                    miss_clr_i
);

    typedef struct packed {
        logic                 en;
        logic [AddrWidth-1:0] start_addr;
        logic [AddrWidth-1:0] end_addr;
        logic [IdxWidth-1:0]  idx;
    } rule_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COMMIT
    } state_t;

    state_t state_q, state_d;
    rule_t  shadow_q [NoRules];
    rule_t  active_q [NoRules];

    logic                cfg_acc, cfg_bad, req_acc;
    logic                hit, miss;
    logic [IdxWidth-1:0] hit_idx, dec_idx;

    // In NAPOT mode the end field carries the mask; otherwise it is an exclusive
    // upper bound where zero stands for the top of the address space.
    function automatic logic rule_match(input rule_t r, input logic [AddrWidth-1:0] a);
        if (Napot) begin
            return (a & r.end_addr) == (r.start_addr & r.end_addr);
        end
        return (a >= r.start_addr) && ((a < r.end_addr) || (r.end_addr == '0));
    endfunction

    assign cfg_ready_o = (state_q == IDLE);
    assign cfg_busy_o  = (state_q != IDLE);
    assign req_ready_o = (state_q == IDLE) && (!rsp_valid_o || rsp_ready_i);
    assign cfg_acc     = cfg_valid_i && cfg_ready_o;
    assign req_acc     = req_valid_i && req_ready_o;
    assign cfg_bad     = (32'(cfg_sel_i) >= NoRules) ||
                         (cfg_en_i && (32'(cfg_idx_i) >= NoIndices));

    // Ascending scan so a later (higher) matching slot overrides earlier ones.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NoRules; i++) begin
            if (active_q[i].en && rule_match(active_q[i], req_addr_i)) begin
                hit     = 1'b1;
                hit_idx = active_q[i].idx;
            end
        end
    end

    assign miss    = !hit && !en_default_idx_i;
    assign dec_idx = hit ? hit_idx : (en_default_idx_i ? default_idx_i : '0);

    // The handshake in the same cycle counts as drained because DRAIN blocks new requests.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cfg_commit_i) state_d = DRAIN;
            DRAIN:   if (!rsp_valid_o || rsp_ready_i) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cfg_err_o  <= 1'b0;
            cfg_done_o <= 1'b0;
            for (int i = 0; i < NoRules; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cfg_err_o  <= cfg_acc && cfg_bad;
            cfg_done_o <= (state_q == COMMIT);
            if (cfg_acc && !cfg_bad) begin
                shadow_q[cfg_sel_i] <= {cfg_en_i, cfg_start_i, cfg_end_i, cfg_idx_i};
            end
            if (state_q == COMMIT) begin
                for (int i = 0; i < NoRules; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_idx_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else if (req_acc) begin
            rsp_valid_o <= 1'b1;
            rsp_idx_o   <= dec_idx;
            rsp_err_o   <= miss;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || miss_clr_i) begin
            miss_cnt_o <= '0;
        end else if (req_acc && miss && (miss_cnt_o != '1)) begin
            miss_cnt_o <= miss_cnt_o + 1'b1;
        end
    end

    a_rsp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_idx_o) && $stable(rsp_err_o)));

    a_ready_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != IDLE) |-> !req_ready_o);

    a_done_after_commit: assert property (@(posedge clk_i) disable iff (rst_i)
        cfg_done_o |-> ($past(state_q) == COMMIT));

endmodule

// File: tb/tb_addr_decode_shadowed.sv
// tb/tb_addr_decode_shadowed.sv - directed bench for addr_decode_shadowed, range and NAPOT instances against a behavioural model
module tb_addr_decode_shadowed;

    localparam int NR = 5;
    localparam int NI = 3;
    localparam int IW = 2;
    localparam int SW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cfg_valid_i = 1'b0;
    logic [SW-1:0] cfg_sel_i = '0;
    logic          cfg_en_i = 1'b0;
    logic [31:0]   cfg_start_i = '0;
    logic [31:0]   cfg_end_i = '0;
    logic [IW-1:0] cfg_idx_i = '0;
    logic          cfg_commit_i = 1'b0;
    logic          en_default_idx_i = 1'b0;
    logic [IW-1:0] default_idx_i = '0;
    logic          req_valid_i = 1'b0;
    logic [31:0]   req_addr_i = '0;
    logic          rsp_ready_i = 1'b1;
    logic          miss_clr_i = 1'b0;

    logic          r_cfg_ready, r_cfg_err, r_cfg_busy, r_cfg_done, r_req_ready, r_rsp_valid, r_rsp_err;
    logic [IW-1:0] r_rsp_idx;
    logic [15:0]   r_miss;
    logic          n_cfg_ready, n_cfg_err, n_cfg_busy, n_cfg_done, n_req_ready, n_rsp_valid, n_rsp_err;
    logic [IW-1:0] n_rsp_idx;
    logic [1:0]    n_miss;

    always #5 clk_i = ~clk_i;

    addr_decode_shadowed #(.NoIndices(NI), .NoRules(NR), .AddrWidth(32), .Napot(1'b0), .MissCntWidth(16)) u_rng (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(r_cfg_ready),
        .cfg_sel_i(cfg_sel_i), .cfg_en_i(cfg_en_i), .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i),
        .cfg_idx_i(cfg_idx_i), .cfg_err_o(r_cfg_err), .cfg_commit_i(cfg_commit_i), .cfg_busy_o(r_cfg_busy),
        .cfg_done_o(r_cfg_done), .en_default_idx_i(en_default_idx_i), .default_idx_i(default_idx_i),
        .req_valid_i(req_valid_i), .req_ready_o(r_req_ready), .req_addr_i(req_addr_i),
        .rsp_valid_o(r_rsp_valid), .rsp_ready_i(rsp_ready_i), .rsp_idx_o(r_rsp_idx), .rsp_err_o(r_rsp_err),
        .miss_cnt_o(r_miss), .miss_clr_i(miss_clr_i));

    addr_decode_shadowed #(.NoIndices(NI), .NoRules(NR), .AddrWidth(32), .Napot(1'b1), .MissCntWidth(2)) u_nap (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(n_cfg_ready),
        .cfg_sel_i(cfg_sel_i), .cfg_en_i(cfg_en_i), .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i),
        .cfg_idx_i(cfg_idx_i), .cfg_err_o(n_cfg_err), .cfg_commit_i(cfg_commit_i), .cfg_busy_o(n_cfg_busy),
        .cfg_done_o(n_cfg_done), .en_default_idx_i(en_default_idx_i), .default_idx_i(default_idx_i),
        .req_valid_i(req_valid_i), .req_ready_o(n_req_ready), .req_addr_i(req_addr_i),
        .rsp_valid_o(n_rsp_valid), .rsp_ready_i(rsp_ready_i), .rsp_idx_o(n_rsp_idx), .rsp_err_o(n_rsp_err),
        .miss_cnt_o(n_miss), .miss_clr_i(miss_clr_i));

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: rule tables as plain arrays, commit progress as a phase number
    // (0 idle, 1 waiting for the output to empty, 2 copying).
    logic          s_en [NR], a_en [NR];
    logic [31:0]   s_st [NR], a_st [NR], s_nd [NR], a_nd [NR];
    logic [IW-1:0] s_ix [NR], a_ix [NR];
    int            m_phase;
    bit            m_valid, m_cerr, m_done, m_started;
    logic [IW-1:0] m_ridx, m_nidx;
    bit            m_rerr, m_nerr;
    int            m_rmiss, m_nmiss;
    bit            m_rdy, m_acc, m_cacc, m_bad, m_old_valid;

    function automatic bit rule_hit(input bit napot, input int i, input logic [31:0] a);
        if (napot) return (a & a_nd[i]) == (a_st[i] & a_nd[i]);
        return (a >= a_st[i]) && (a_nd[i] == 0 || a < a_nd[i]);
    endfunction

    // Highest enabled matching slot decides; otherwise default or error.
    task automatic model_decode(input bit napot, input logic [31:0] a, output logic [IW-1:0] idx, output bit err);
        for (int i = NR - 1; i >= 0; i--) begin
            if (a_en[i] && rule_hit(napot, i, a)) begin
                idx = a_ix[i];
                err = 1'b0;
                return;
            end
        end
        idx = en_default_idx_i ? default_idx_i : '0;
        err = !en_default_idx_i;
    endtask

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR; i++) begin
                s_en[i] = 0; s_st[i] = 0; s_nd[i] = 0; s_ix[i] = 0;
                a_en[i] = 0; a_st[i] = 0; a_nd[i] = 0; a_ix[i] = 0;
            end
            m_phase = 0; m_valid = 0; m_cerr = 0; m_done = 0;
            m_ridx = 0; m_nidx = 0; m_rerr = 0; m_nerr = 0; m_rmiss = 0; m_nmiss = 0;
            m_started = 1;
        end else begin
            m_rdy       = (m_phase == 0) && (!m_valid || rsp_ready_i);
            m_acc       = req_valid_i && m_rdy;
            m_cacc      = cfg_valid_i && (m_phase == 0);
            m_bad       = (int'(cfg_sel_i) >= NR) || (cfg_en_i && int'(cfg_idx_i) >= NI);
            m_old_valid = m_valid;
            m_done      = (m_phase == 2);
            m_cerr      = m_cacc && m_bad;
            if (m_acc) begin
                model_decode(1'b0, req_addr_i, m_ridx, m_rerr);
                model_decode(1'b1, req_addr_i, m_nidx, m_nerr);
                m_valid = 1;
            end else if (rsp_ready_i) begin
                m_valid = 0;
            end
            if (miss_clr_i) begin
                m_rmiss = 0;
                m_nmiss = 0;
            end else if (m_acc) begin
                if (m_rerr && m_rmiss < 65535) m_rmiss++;
                if (m_nerr && m_nmiss < 3) m_nmiss++;
            end
            case (m_phase)
                0: if (cfg_commit_i) m_phase = 1;
                1: if (!m_old_valid || rsp_ready_i) m_phase = 2;
                default: begin
                    for (int i = 0; i < NR; i++) begin
                        a_en[i] = s_en[i]; a_st[i] = s_st[i]; a_nd[i] = s_nd[i]; a_ix[i] = s_ix[i];
                    end
                    m_phase = 0;
                end
            endcase
            if (m_cacc && !m_bad) begin
                s_en[cfg_sel_i] = cfg_en_i;
                s_st[cfg_sel_i] = cfg_start_i;
                s_nd[cfg_sel_i] = cfg_end_i;
                s_ix[cfg_sel_i] = cfg_idx_i;
            end
        end
    end

    always @(negedge clk_i) begin
        if (m_started) begin
            chk("cfg_ready", {31'd0, r_cfg_ready}, {31'd0, m_phase == 0});
            chk("cfg_busy", {31'd0, r_cfg_busy}, {31'd0, m_phase != 0});
            chk("cfg_err", {31'd0, r_cfg_err}, {31'd0, m_cerr});
            chk("cfg_done", {31'd0, r_cfg_done}, {31'd0, m_done});
            chk("req_ready", {31'd0, r_req_ready}, {31'd0, (m_phase == 0) && (!m_valid || rsp_ready_i)});
            chk("rsp_valid", {31'd0, r_rsp_valid}, {31'd0, m_valid});
            chk("miss_cnt", {16'd0, r_miss}, m_rmiss);
            chk("nap_cfg_err", {31'd0, n_cfg_err}, {31'd0, m_cerr});
            chk("nap_cfg_done", {31'd0, n_cfg_done}, {31'd0, m_done});
            chk("nap_cfg_ready", {31'd0, n_cfg_ready & ~n_cfg_busy}, {31'd0, m_phase == 0});
            chk("nap_req_ready", {31'd0, n_req_ready}, {31'd0, (m_phase == 0) && (!m_valid || rsp_ready_i)});
            chk("nap_rsp_valid", {31'd0, n_rsp_valid}, {31'd0, m_valid});
            chk("nap_miss_cnt", {30'd0, n_miss}, m_nmiss);
            if (m_valid) begin
                chk("rsp_idx", {30'd0, r_rsp_idx}, {30'd0, m_ridx});
                chk("rsp_err", {31'd0, r_rsp_err}, {31'd0, m_rerr});
                chk("nap_rsp_idx", {30'd0, n_rsp_idx}, {30'd0, m_nidx});
                chk("nap_rsp_err", {31'd0, n_rsp_err}, {31'd0, m_nerr});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_write(input int sel, input bit en, input logic [31:0] s, input logic [31:0] e, input int idx);
        cfg_valid_i = 1'b1;
        cfg_sel_i   = SW'(sel);
        cfg_en_i    = en;
        cfg_start_i = s;
        cfg_end_i   = e;
        cfg_idx_i   = IW'(idx);
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit_i = 1'b1;
        tick();
        cfg_commit_i = 1'b0;
        tick();
        chk("done_not_early", {31'd0, r_cfg_done}, 32'd0);
        tick();
        chk("done_two_after_commit", {31'd0, r_cfg_done}, 32'd1);
    endtask

    task automatic decode(input logic [31:0] a);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        tick();
        req_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) tick();
        rst_i = 1'b0;
        chk("reset_rsp_valid", {31'd0, r_rsp_valid}, 32'd0);
        chk("reset_rsp_idx", {30'd0, r_rsp_idx}, 32'd0);
        chk("reset_rsp_err", {31'd0, r_rsp_err}, 32'd0);
        chk("reset_cfg_ready", {31'd0, r_cfg_ready}, 32'd1);
        chk("reset_miss", {16'd0, r_miss}, 32'd0);

        decode(32'h1000);
        chk("empty_valid", {31'd0, r_rsp_valid}, 32'd1);
        chk("empty_err", {31'd0, r_rsp_err}, 32'd1);
        chk("empty_idx", {30'd0, r_rsp_idx}, 32'd0);
        chk("empty_miss", {16'd0, r_miss}, 32'd1);

        cfg_write(0, 1, 32'h0, 32'h2000, 1);
        decode(32'h1000);
        chk("shadow_invisible_err", {31'd0, r_rsp_err}, 32'd1);
        chk("shadow_invisible_miss", {16'd0, r_miss}, 32'd2);
        do_commit();
        decode(32'h1000);
        chk("committed_idx", {30'd0, r_rsp_idx}, 32'd1);
        chk("committed_err", {31'd0, r_rsp_err}, 32'd0);

        cfg_write(0, 1, 32'h0, 32'h0, 1);
        cfg_write(3, 1, 32'h4000, 32'h5000, 0);
        do_commit();
        decode(32'h4800);
        chk("overlap_hi_slot", {30'd0, r_rsp_idx}, 32'd0);
        decode(32'h6000);
        chk("overlap_top_of_space", {30'd0, r_rsp_idx}, 32'd1);

        // Commit while the 0x6000 result is held; slot3 is disabled in the same cycle.
        rsp_ready_i  = 1'b0;
        cfg_commit_i = 1'b1;
        cfg_valid_i  = 1'b1;
        cfg_sel_i    = 3'd3;
        cfg_en_i     = 1'b0;
        cfg_start_i  = 32'h0;
        cfg_end_i    = 32'h0;
        cfg_idx_i    = 2'd0;
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h4800;
        tick();
        cfg_commit_i = 1'b0;
        cfg_valid_i  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("held_req_ready", {31'd0, r_req_ready}, 32'd0);
            chk("held_rsp_valid", {31'd0, r_rsp_valid}, 32'd1);
            chk("held_rsp_idx", {30'd0, r_rsp_idx}, 32'd1);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt++;
            if (r_cfg_done) break;
        end
        chk("done_after_handshake", cnt, 32'd1);
        tick();
        req_valid_i = 1'b0;
        chk("after_drain_idx", {30'd0, r_rsp_idx}, 32'd1);
        chk("after_drain_err", {31'd0, r_rsp_err}, 32'd0);

        cfg_write(5, 1, 32'h0, 32'h100, 1);
        chk("bad_sel_err", {31'd0, r_cfg_err}, 32'd1);
        tick();
        chk("err_is_pulse", {31'd0, r_cfg_err}, 32'd0);
        cfg_write(3, 1, 32'h4000, 32'h5000, 3);
        chk("bad_idx_err", {31'd0, r_cfg_err}, 32'd1);
        do_commit();
        decode(32'h4800);
        chk("bad_write_ignored", {30'd0, r_rsp_idx}, 32'd1);

        cfg_write(0, 0, 32'h0, 32'h0, 0);
        cfg_write(1, 1, 32'h3000, 32'hFFFF_F000, 1);
        do_commit();
        decode(32'h3ABC);
        chk("napot_hit_idx", {30'd0, n_rsp_idx}, 32'd1);
        chk("napot_hit_err", {31'd0, n_rsp_err}, 32'd0);
        en_default_idx_i = 1'b1;
        default_idx_i    = 2'd0;
        decode(32'h4000);
        chk("napot_default0_idx", {30'd0, n_rsp_idx}, 32'd0);
        chk("napot_default0_err", {31'd0, n_rsp_err}, 32'd0);
        chk("range_wide_idx", {30'd0, r_rsp_idx}, 32'd1);
        default_idx_i = 2'd2;
        decode(32'h4000);
        chk("napot_default2_idx", {30'd0, n_rsp_idx}, 32'd2);
        en_default_idx_i = 1'b0;
        default_idx_i    = 2'd0;

        miss_clr_i = 1'b1;
        tick();
        miss_clr_i = 1'b0;
        chk("miss_cleared", {30'd0, n_miss}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            decode(32'h4000);
            if (i == 2) chk("miss_three", {30'd0, n_miss}, 32'd3);
        end
        chk("miss_saturated", {30'd0, n_miss}, 32'd3);
        miss_clr_i = 1'b1;
        decode(32'h4000);
        miss_clr_i = 1'b0;
        chk("miss_clr_priority", {30'd0, n_miss}, 32'd0);
        chk("miss_clr_rsp_err", {31'd0, n_rsp_err}, 32'd1);

        // Reset in the middle of a pending commit with a held response.
        decode(32'h3ABC);
        rsp_ready_i  = 1'b0;
        cfg_commit_i = 1'b1;
        tick();
        cfg_commit_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        chk("midrst_rsp_valid", {31'd0, r_rsp_valid}, 32'd0);
        chk("midrst_busy", {31'd0, r_cfg_busy}, 32'd0);
        decode(32'h3ABC);
        chk("midrst_table_cleared", {31'd0, r_rsp_err}, 32'd1);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
